// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and hands {pc, instr}
// pairs to decode over valid/ready, with a one-entry hold buffer and redirect flushing.
module ifetch #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_err,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  localparam logic [XLEN-1:0] RESET_FETCH = RESET_PC[XLEN-1:0];
  localparam logic [31:0]     NOP         = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_hold_pc;
  logic [31:0]     r_hold_instr;
  logic            r_drop;
  logic            r_id_valid;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_misalign;

  logic            w_req_fire;
  logic            w_resp;
  logic            w_slot_free;
  logic            w_load_mem;
  logic            w_to_hold;
  logic            w_load_hold;
  logic [XLEN-1:0] w_redirect_addr;

  // Request is masked during reset and in the redirect cycle so no stale-path fetch escapes.
  assign imem_req_valid  = resetn && (r_state == S_REQ) && !redirect_valid;
  assign imem_addr       = r_fetch_pc;
  assign misalign_err    = r_misalign;
  assign id_valid        = r_id_valid;
  assign pc              = r_pc;
  assign instr           = r_instr;

  assign w_req_fire      = imem_req_valid && imem_req_ready;
  assign w_resp          = (r_state == S_WAIT) && imem_resp_valid;
  assign w_slot_free     = !r_id_valid || id_ready;
  assign w_load_mem      = !redirect_valid && w_resp && !r_drop && w_slot_free;
  assign w_to_hold       = !redirect_valid && w_resp && !r_drop && !w_slot_free;
  assign w_load_hold     = !redirect_valid && (r_state == S_HOLD) && id_ready;
  assign w_redirect_addr = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_REQ: begin
        if (!redirect_valid && w_req_fire) begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          w_next_state = w_to_hold ? S_HOLD : S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid || id_ready) begin
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fetch_pc   <= RESET_FETCH;
      r_req_pc     <= '0;
      r_hold_pc    <= '0;
      r_hold_instr <= NOP;
      r_drop       <= 1'b0;
      r_id_valid   <= 1'b0;
      r_pc         <= '0;
      r_instr      <= NOP;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        // A response still in flight after the flush must be swallowed when it lands.
        r_fetch_pc <= w_redirect_addr;
        r_id_valid <= 1'b0;
        r_drop     <= (r_state == S_WAIT) && !imem_resp_valid;
      end else begin
        if (w_req_fire) begin
          r_req_pc   <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + XLEN'(4);
        end
        if (w_resp) begin
          r_drop <= 1'b0;
        end
        if (w_load_mem) begin
          r_pc       <= r_req_pc;
          r_instr    <= imem_rdata;
          r_id_valid <= 1'b1;
        end else if (w_load_hold) begin
          r_pc       <= r_hold_pc;
          r_instr    <= r_hold_instr;
          r_id_valid <= 1'b1;
        end else if (r_id_valid && id_ready) begin
          r_id_valid <= 1'b0;
        end
        if (w_to_hold) begin
          r_hold_pc    <= r_req_pc;
          r_hold_instr <= imem_rdata;
        end
      end
    end
  end

endmodule
